// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-stage register info in, stall/flush/forward controls out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 16
);
  logic [RW-1:0]    id_rs1;
  logic [RW-1:0]    id_rs2;
  logic             id_use1;
  logic             id_use2;
  logic [RW-1:0]    ex_rs1;
  logic [RW-1:0]    ex_rs2;
  logic [RW-1:0]    ex_rd;
  logic             ex_regwe;
  logic             ex_memrd;
  logic [RW-1:0]    mem_rd;
  logic             mem_regwe;
  logic             mem_memrd;
  logic [RW-1:0]    wb_rd;
  logic             wb_regwe;
  logic             redirect;
  logic             dmem_req;
  logic             dmem_ready;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall_pc;
  logic             stall_ifid;
  logic             bubble_idex;
  logic             flush_ifid;
  logic             flush_idex;
  logic             freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             err_timeout;

  // Pipeline side: supplies stage info, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd, ex_regwe, ex_memrd,
           mem_rd, mem_regwe, mem_memrd, wb_rd, wb_regwe, redirect, dmem_req, dmem_ready,
    input  fwd_a, fwd_b, stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, freeze,
           stall_cnt, flush_cnt, err_timeout
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd, ex_regwe, ex_memrd,
           mem_rd, mem_regwe, mem_memrd, wb_rd, wb_regwe, redirect, dmem_req, dmem_ready,
    output fwd_a, fwd_b, stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, freeze,
           stall_cnt, flush_cnt, err_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32 core: load-use stall (multi-cycle), redirect
// flush, EX forwarding select, data-memory freeze, saturating perf counters and freeze watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned LOAD_LAT = 0,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  pipe_hazard_ctrl_if.slave   hz
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned FW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0]  LuInit = 3'(LOAD_LAT);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLdUse   = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       saved_q, saved_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [FW-1:0]    frz_cnt_q, frz_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic             freeze_raw;
  logic             lu_hit;
  logic             stall_raw;
  logic             flush_raw;
  logic [1:0]       eff_state;

  // EX/MEM beats WB; loads in EX/MEM have no data yet; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] rs,
                                         input logic [RW-1:0] m_rd,
                                         input logic          m_we,
                                         input logic          m_ld,
                                         input logic [RW-1:0] w_rd,
                                         input logic          w_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (m_we && (m_rd == rs) && !m_ld) begin
        sel = 2'b10;
      end else if (w_we && (w_rd == rs)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Hazard detection and FSM next state; MEMWAIT behaves as its saved state once unfrozen.
  always_comb begin
    freeze_raw = hz.dmem_req & ~hz.dmem_ready;
    lu_hit     = hz.ex_memrd & hz.ex_regwe & (hz.ex_rd != '0) &
                 ((hz.id_use1 & (hz.id_rs1 == hz.ex_rd)) |
                  (hz.id_use2 & (hz.id_rs2 == hz.ex_rd)));
    eff_state  = (state_q == StMemWait) ? saved_q : state_q;
    state_d    = state_q;
    saved_d    = saved_q;
    lu_cnt_d   = lu_cnt_q;
    stall_raw  = 1'b0;
    flush_raw  = 1'b0;
    if (freeze_raw) begin
      if (state_q != StMemWait) begin
        saved_d = state_q;
        state_d = StMemWait;
      end
    end else if (hz.redirect) begin
      // Redirect wins over load-use and aborts any multi-cycle stall.
      flush_raw = 1'b1;
      state_d   = StRun;
      lu_cnt_d  = '0;
    end else begin
      case (eff_state)
        StLdUse: begin
          stall_raw = 1'b1;
          if (lu_cnt_q <= 3'd1) begin
            state_d  = StRun;
            lu_cnt_d = '0;
          end else begin
            state_d  = StLdUse;
            lu_cnt_d = lu_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = StRun;
          if (lu_hit) begin
            stall_raw = 1'b1;
            if (LOAD_LAT > 0) begin
              state_d  = StLdUse;
              lu_cnt_d = LuInit;
            end
          end
        end
      endcase
    end
  end

  // Watchdog and saturating performance counters.
  always_comb begin
    frz_cnt_d   = '0;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze_raw) begin
      frz_cnt_d = (frz_cnt_q == FW'(TIMEOUT)) ? frz_cnt_q : frz_cnt_q + FW'(1);
      if (frz_cnt_d == FW'(TIMEOUT)) begin
        err_d = 1'b1;
      end
    end
    if ((stall_raw || freeze_raw) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_raw && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      saved_q     <= StRun;
      lu_cnt_q    <= '0;
      frz_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      lu_cnt_q    <= lu_cnt_d;
      frz_cnt_q   <= frz_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  // Outputs: combinational paths are forced low while reset is asserted.
  always_comb begin
    hz.fwd_a       = 2'b00;
    hz.fwd_b       = 2'b00;
    hz.stall_pc    = 1'b0;
    hz.stall_ifid  = 1'b0;
    hz.bubble_idex = 1'b0;
    hz.flush_ifid  = 1'b0;
    hz.flush_idex  = 1'b0;
    hz.freeze      = 1'b0;
    hz.stall_cnt   = stall_cnt_q;
    hz.flush_cnt   = flush_cnt_q;
    hz.err_timeout = err_q;
    if (rst_ni) begin
      hz.fwd_a       = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_regwe, hz.mem_memrd,
                               hz.wb_rd, hz.wb_regwe);
      hz.fwd_b       = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_regwe, hz.mem_memrd,
                               hz.wb_rd, hz.wb_regwe);
      hz.stall_pc    = stall_raw;
      hz.stall_ifid  = stall_raw;
      hz.bubble_idex = stall_raw;
      hz.flush_ifid  = flush_raw;
      hz.flush_idex  = flush_raw;
      hz.freeze      = freeze_raw;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors queued at drive time, popped and
// compared at the falling edge. Main DUT uses LOAD_LAT=2, a second copy uses LOAD_LAT=0.
module tb_pipe_hazard_ctrl;
  // ctl layout: {fwd_a[1:0], fwd_b[1:0], stall_pc, stall_ifid, bubble_idex,
  //              flush_ifid, flush_idex, freeze, err_timeout}
  localparam logic [10:0] C0    = 11'h000;
  localparam logic [10:0] STALL = 11'h070;
  localparam logic [10:0] FLUSH = 11'h00C;
  localparam logic [10:0] FRZ   = 11'h002;
  localparam logic [10:0] ERR   = 11'h001;

  typedef struct {
    string       tag;
    logic [42:0] exp;
  } item_t;

  logic        clk_i;
  logic        rst_ni;
  item_t       sb[$];
  int          checks;
  int          failures;
  logic [15:0] scnt_m;
  logic [15:0] fcnt_m;

  pipe_hazard_ctrl_if #(.RW(5), .CNT_W(16)) hif ();
  pipe_hazard_ctrl_if #(.RW(5), .CNT_W(16)) hif0 ();

  pipe_hazard_ctrl #(.NREG(32), .LOAD_LAT(2), .CNT_W(16), .TIMEOUT(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .hz     (hif.slave)
  );

  pipe_hazard_ctrl #(.NREG(32), .LOAD_LAT(0), .CNT_W(16), .TIMEOUT(8)) dut0 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .hz     (hif0.slave)
  );

  assign hif0.id_rs1     = hif.id_rs1;
  assign hif0.id_rs2     = hif.id_rs2;
  assign hif0.id_use1    = hif.id_use1;
  assign hif0.id_use2    = hif.id_use2;
  assign hif0.ex_rs1     = hif.ex_rs1;
  assign hif0.ex_rs2     = hif.ex_rs2;
  assign hif0.ex_rd      = hif.ex_rd;
  assign hif0.ex_regwe   = hif.ex_regwe;
  assign hif0.ex_memrd   = hif.ex_memrd;
  assign hif0.mem_rd     = hif.mem_rd;
  assign hif0.mem_regwe  = hif.mem_regwe;
  assign hif0.mem_memrd  = hif.mem_memrd;
  assign hif0.wb_rd      = hif.wb_rd;
  assign hif0.wb_regwe   = hif.wb_regwe;
  assign hif0.redirect   = hif.redirect;
  assign hif0.dmem_req   = hif.dmem_req;
  assign hif0.dmem_ready = hif.dmem_ready;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [42:0] obs_main();
    return {hif.fwd_a, hif.fwd_b, hif.stall_pc, hif.stall_ifid, hif.bubble_idex,
            hif.flush_ifid, hif.flush_idex, hif.freeze, hif.err_timeout,
            hif.stall_cnt, hif.flush_cnt};
  endfunction

  function automatic logic [42:0] obs_dut0();
    return {hif0.fwd_a, hif0.fwd_b, hif0.stall_pc, hif0.stall_ifid, hif0.bubble_idex,
            hif0.flush_ifid, hif0.flush_idex, hif0.freeze, hif0.err_timeout,
            hif0.stall_cnt, hif0.flush_cnt};
  endfunction

  task automatic chk(input string tag, input logic [42:0] obs, input logic [42:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_use1 = 1'b0; hif.id_use2 = 1'b0;
    hif.ex_rs1 = '0; hif.ex_rs2 = '0; hif.ex_rd = '0; hif.ex_regwe = 1'b0;
    hif.ex_memrd = 1'b0; hif.mem_rd = '0; hif.mem_regwe = 1'b0; hif.mem_memrd = 1'b0;
    hif.wb_rd = '0; hif.wb_regwe = 1'b0; hif.redirect = 1'b0;
    hif.dmem_req = 1'b0; hif.dmem_ready = 1'b0;
  endtask

  task automatic lu_hit_in();
    hif.ex_memrd = 1'b1; hif.ex_regwe = 1'b1; hif.ex_rd = 5'd5;
    hif.id_rs1 = 5'd5; hif.id_use1 = 1'b1;
  endtask

  // One clock: queue expectation (with modelled counter values), compare at negedge, advance model.
  task automatic cycle(input string tag, input logic [10:0] ctl,
                       input bit chk0, input logic [42:0] exp0);
    item_t it;
    it.tag = tag;
    it.exp = {ctl, scnt_m, fcnt_m};
    sb.push_back(it);
    @(negedge clk_i);
    it = sb.pop_front();
    chk(it.tag, obs_main(), it.exp);
    if (chk0) chk({it.tag, "_lat0"}, obs_dut0(), exp0);
    if ((ctl[6] || ctl[1]) && (scnt_m != 16'hFFFF)) scnt_m++;
    if (ctl[3] && (fcnt_m != 16'hFFFF)) fcnt_m++;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    scnt_m   = '0;
    fcnt_m   = '0;
    rst_ni   = 1'b0;
    clr();
    // Inputs that would raise freeze/forwarding must be masked during reset.
    hif.dmem_req = 1'b1; hif.ex_rs1 = 5'd7; hif.mem_rd = 5'd7; hif.mem_regwe = 1'b1;
    #2;
    chk("reset_main", obs_main(), 43'h0);
    chk("reset_lat0", obs_dut0(), 43'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    clr();

    // Load-use: single bubble at LOAD_LAT=0, three at LOAD_LAT=2.
    lu_hit_in();
    cycle("lu_hit", STALL, 1'b1, {STALL, 16'd0, 16'd0});
    clr();
    cycle("lu_lat1", STALL, 1'b1, {C0, 16'd1, 16'd0});
    cycle("lu_lat2", STALL, 1'b0, '0);
    cycle("lu_done", C0, 1'b0, '0);
    cycle("lu_idle", C0, 1'b0, '0);

    // Load-use qualifiers.
    lu_hit_in(); hif.id_use1 = 1'b0;
    cycle("lu_nouse", C0, 1'b0, '0);
    lu_hit_in(); hif.ex_rd = 5'd0; hif.id_rs1 = 5'd0;
    cycle("lu_rd0", C0, 1'b0, '0);
    clr();

    // Forwarding patterns.
    hif.mem_rd = 5'd7; hif.mem_regwe = 1'b1; hif.wb_rd = 5'd7; hif.wb_regwe = 1'b1;
    hif.ex_rs1 = 5'd7; hif.ex_rs2 = 5'd0;
    cycle("fwd_mem_prio", 11'h400, 1'b0, '0);
    hif.mem_memrd = 1'b1;
    cycle("fwd_load_wb", 11'h200, 1'b0, '0);
    hif.mem_memrd = 1'b0; hif.ex_rs2 = 5'd7;
    cycle("fwd_both_mem", 11'h500, 1'b0, '0);
    hif.mem_regwe = 1'b0;
    cycle("fwd_both_wb", 11'h280, 1'b0, '0);
    clr();
    hif.wb_rd = 5'd0; hif.wb_regwe = 1'b1;
    cycle("fwd_x0", C0, 1'b0, '0);
    clr();

    // Simultaneous hit and redirect: redirect wins, no LDUSE entry.
    lu_hit_in(); hif.redirect = 1'b1;
    cycle("hit_redir", FLUSH, 1'b0, '0);
    clr();
    cycle("hit_redir_after", C0, 1'b0, '0);

    // Redirect aborts LDUSE.
    lu_hit_in();
    cycle("abort_hit", STALL, 1'b0, '0);
    clr(); hif.redirect = 1'b1;
    cycle("abort_flush", FLUSH, 1'b0, '0);
    clr();
    cycle("abort_run", C0, 1'b0, '0);

    // Freeze inside LDUSE holds lu_cnt; forwarding stays live.
    lu_hit_in();
    cycle("ldfrz_hit", STALL, 1'b0, '0);
    clr(); hif.dmem_req = 1'b1;
    hif.ex_rs1 = 5'd7; hif.mem_rd = 5'd7; hif.mem_regwe = 1'b1;
    cycle("ldfrz_f1", FRZ | 11'h400, 1'b0, '0);
    cycle("ldfrz_f2", FRZ | 11'h400, 1'b0, '0);
    clr(); hif.dmem_req = 1'b1; hif.dmem_ready = 1'b1;
    cycle("ldfrz_s1", STALL, 1'b0, '0);
    clr();
    cycle("ldfrz_s2", STALL, 1'b0, '0);
    cycle("ldfrz_run", C0, 1'b0, '0);

    // Redirect held through freeze applies once on the first unfrozen cycle.
    hif.dmem_req = 1'b1; hif.redirect = 1'b1;
    for (int i = 0; i < 4; i++) cycle("frz_redir", FRZ, 1'b0, '0);
    hif.dmem_ready = 1'b1;
    cycle("frz_redir_apply", FLUSH, 1'b0, '0);
    clr();
    cycle("frz_redir_done", C0, 1'b0, '0);

    // Watchdog: error after TIMEOUT frozen cycles, sticky after ready.
    hif.dmem_req = 1'b1;
    for (int i = 0; i < 8; i++) cycle("wdog_frz", FRZ, 1'b0, '0);
    cycle("wdog_err", FRZ | ERR, 1'b0, '0);
    hif.dmem_ready = 1'b1;
    cycle("wdog_ready", ERR, 1'b0, '0);
    clr();
    cycle("wdog_sticky", ERR, 1'b0, '0);

    // Reset mid-LDUSE clears outputs immediately; FSM restarts in RUN.
    lu_hit_in();
    cycle("rst_hit", STALL | ERR, 1'b0, '0);
    clr();
    cycle("rst_ldu", STALL | ERR, 1'b0, '0);
    hif.dmem_req = 1'b1; hif.redirect = 1'b1;
    hif.ex_rs1 = 5'd7; hif.mem_rd = 5'd7; hif.mem_regwe = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_main", obs_main(), 43'h0);
    chk("rst_mid_lat0", obs_dut0(), 43'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    scnt_m = '0;
    fcnt_m = '0;
    clr();
    cycle("post_rst_run", C0, 1'b0, '0);
    lu_hit_in();
    cycle("post_rst_hit", STALL, 1'b0, '0);
    clr();
    cycle("post_rst_ldu", STALL, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
